// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic valid/ready pipeline stage with a main+skid buffer
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous flush; empties the stage, drops any word offered that cycle
//   in_valid   upstream word present
//   in_data    upstream payload
//   in_ready   stage can accept (registered)
//   out_valid  word available downstream (registered)
//   out_data   downstream payload, always the main entry
//   out_ready  downstream accepts this cycle
//   occupancy  entries held: 0, 1 or 2
module pipe_skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] main_q, skid_q;
  logic in_fire, out_fire, main_load, skid_load;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state;
  always_comb begin
    state_next = state;
    main_load  = 1'b0;
    skid_load  = 1'b0;
    if (state == EMPTY) begin
      state_next = in_fire ? BUSY : EMPTY;
      main_load  = in_fire;
    end else if (state == BUSY) begin
      state_next = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : BUSY;
      main_load  = in_fire & out_fire;
      skid_load  = in_fire & ~out_fire;
    end else if (state == FULL) begin
      state_next = out_fire ? BUSY : FULL;
      main_load  = out_fire;
    end else begin
      state_next = EMPTY;
    end
    if (flush) begin
      state_next = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end
  // Handshake outputs are decoded from the next state and registered so no
  // combinational path runs from out_ready to in_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= state_next != FULL;
      out_valid <= state_next != EMPTY;
      if (main_load) main_q <= (state == FULL) ? skid_q : in_data;
      if (skid_load) skid_q <= in_data;
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed table-driven checks of pipe_skid_stage
module tb_pipe_skid_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [1:0]  occupancy;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ir;
    logic [1:0]  e_occ;
  } vec_t;
  vec_t vecs[$];
  pipe_skid_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic ov, input logic [31:0] od, input logic ir, input logic [1:0] occ);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, "_out_data"}, out_data, od);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    chk({tag, "_occupancy"}, {30'd0, occupancy}, {30'd0, occ});
  endtask
  task automatic add(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                     input logic ov, input logic [31:0] od, input logic ir, input logic [1:0] occ);
    vecs.push_back('{iv, d, ordy, fl, ov, od, ir, occ});
  endtask
  initial begin
    // streaming 1..8, 1-cycle latency, in_ready stays high
    for (int i = 1; i <= 8; i++) add(1, i, 1, 0, 1, i, 1, 1);
    add(0, 32'h0, 1, 0, 0, 32'h8, 1, 0);
    // backpressure: A, B fill both entries, C refused until drain
    add(1, 32'hA, 0, 0, 1, 32'hA, 1, 1);
    add(1, 32'hB, 0, 0, 1, 32'hA, 0, 2);
    add(1, 32'hC, 0, 0, 1, 32'hA, 0, 2);
    add(1, 32'hC, 1, 0, 1, 32'hB, 1, 1);
    add(1, 32'hC, 1, 0, 1, 32'hC, 1, 1);
    add(0, 32'h0, 1, 0, 0, 32'hC, 1, 0);
    // simultaneous in/out while FULL: new word D not taken
    add(1, 32'hA, 0, 0, 1, 32'hA, 1, 1);
    add(1, 32'hB, 0, 0, 1, 32'hA, 0, 2);
    add(1, 32'hD, 1, 0, 1, 32'hB, 1, 1);
    add(0, 32'h0, 1, 0, 0, 32'hB, 1, 0);
    // flush from FULL with a word offered: everything dropped
    add(1, 32'h11, 0, 0, 1, 32'h11, 1, 1);
    add(1, 32'h22, 0, 0, 1, 32'h11, 0, 2);
    add(1, 32'h33, 0, 1, 0, 32'h11, 1, 0);
    add(0, 32'h0, 1, 0, 0, 32'h11, 1, 0);
    // flush in BUSY with in_fire and out_fire in the same cycle
    add(1, 32'h55, 0, 0, 1, 32'h55, 1, 1);
    add(1, 32'h66, 1, 1, 0, 32'h55, 1, 0);
    // in_data ignored while in_valid is low
    add(0, 32'hDEADBEEF, 1, 0, 0, 32'h55, 1, 0);
    // test 1: reset held with a word offered
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("reset%0d", i), 0, 32'h0, 1, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_occ);
    end
    // test 6: async reset between edges while BUSY
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_all("pre_async", 1, 32'h77, 1, 1);
    #2 reset = 1'b0;
    #1 chk_all("async_reset", 0, 32'h0, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_all("post_reset", 1, 32'h44, 1, 1);
    @(posedge clk); #1;
    chk_all("post_reset_drain", 0, 32'h44, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
